// File: rtl/ray_pkg.sv
// Shared types for the renderer output path: packed shade type, frame size defaults
// and the output sequencer states.
package ray_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int FRAME_W_DEF = 640;
    localparam int FRAME_H_DEF = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    // Counter width that never collapses to zero bits for a single-value range.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word fall-through FIFO: head is valid whenever empty is low.
// Push is ignored when full and pop is ignored when empty.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are only observed through head while not empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pixel_stream_out.sv
// Shaded-pixel to AXI4-Stream video bridge: buffers pixels in a FWFT FIFO, marks
// start-of-frame on tuser and end-of-line on tlast, and sequences one frame per start.
module pixel_stream_out
    import ray_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int PIX_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [PIX_W-1:0] m_tdata,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             busy,
    output logic             frame_done
);
    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int XW   = cnt_width(FRAME_W);
    localparam int YW   = cnt_width(FRAME_H);

    localparam logic [IW-1:0] NPIX_C    = IW'(NPIX);
    localparam logic [IW-1:0] LAST_IN_C = IW'(NPIX - 1);
    localparam logic [XW-1:0] X_LAST_C  = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST_C  = YW'(FRAME_H - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   in_cnt_q, in_cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;

    logic            fifo_full_s, fifo_empty_s;
    logic [PIX_W-1:0] fifo_head_s;
    logic            accept_s, pop_s, last_beat_s;

    assign pix_ready   = (state_q == ACTIVE) && (in_cnt_q < NPIX_C) && !fifo_full_s;
    assign accept_s    = pix_valid && pix_ready;
    assign m_tvalid    = !fifo_empty_s;
    assign pop_s       = m_tvalid && m_tready;
    assign last_beat_s = pop_s && (x_q == X_LAST_C) && (y_q == Y_LAST_C);

    assign m_tdata     = fifo_empty_s ? {PIX_W{1'b0}} : fifo_head_s;
    assign m_tuser     = m_tvalid && (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
    assign m_tlast     = m_tvalid && (x_q == X_LAST_C);
    assign busy        = (state_q != IDLE);
    // Reset outranks the final handshake so an interrupted frame never reports done.
    assign frame_done  = (state_q == FLUSH) && last_beat_s && !rst;

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .din   (pix_data),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // Frame sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (accept_s && (in_cnt_q == LAST_IN_C)) begin
                    state_d = FLUSH;
                end else begin
                    state_d = ACTIVE;
                end
            end
            FLUSH: begin
                if (last_beat_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input pixel count, cleared when a frame is launched.
    always_comb begin
        in_cnt_d = in_cnt_q;
        if ((state_q == IDLE) && start) begin
            in_cnt_d = {IW{1'b0}};
        end else if (accept_s) begin
            in_cnt_d = in_cnt_q + IW'(1);
        end else begin
            in_cnt_d = in_cnt_q;
        end
    end

    // Output raster position, advanced per handshake; wraps to 0,0 after the last beat.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pop_s) begin
            if (x_q == X_LAST_C) begin
                x_d = {XW{1'b0}};
                if (y_q == Y_LAST_C) begin
                    y_d = {YW{1'b0}};
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            in_cnt_q <= {IW{1'b0}};
            x_q      <= {XW{1'b0}};
            y_q      <= {YW{1'b0}};
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: tb/tb_pixel_stream_out.sv
// Bench for pixel_stream_out on a 4x2 frame with a 4-deep FIFO: queue-based reference
// model checked every cycle, plus directed literal expectations per scenario.
module tb_pixel_stream_out;
    localparam int FW   = 4;
    localparam int FH   = 2;
    localparam int NPIX = FW * FH;
    localparam int DEP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = 24'h0;
    logic        m_tready = 1'b0;
    logic        pix_ready, m_tvalid, m_tuser, m_tlast, busy, frame_done;
    logic [23:0] m_tdata;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [25:0] beat_log [$];
    int          fd_cnt = 0;

    logic [23:0] mq [$];
    int          m_acc = 0;
    int          m_pos = 0;
    bit          m_busy = 1'b0;

    int sent = 0;
    int next_pix = 1;

    pixel_stream_out #(
        .FRAME_W(FW), .FRAME_H(FH), .PIX_W(24), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted pixels and a beat position within the frame.
    initial begin
        bit          e_valid, e_user, e_last, e_ready, e_done, prev_stall;
        logic [23:0] e_data, prev_data;
        logic        prev_user, prev_last;
        prev_stall = 1'b0;
        prev_data = 24'h0;
        prev_user = 1'b0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            e_valid = (mq.size() > 0);
            e_data  = e_valid ? mq[0] : 24'h0;
            e_user  = e_valid && (m_pos == 0);
            e_last  = e_valid && ((m_pos % FW) == FW - 1);
            e_ready = m_busy && (m_acc < NPIX) && (mq.size() < DEP);
            e_done  = !rst && e_valid && m_tready && (m_pos == NPIX - 1);
            if (chk_en) begin
                chk("pix_ready", pix_ready, e_ready);
                chk("m_tvalid", m_tvalid, e_valid);
                chk("m_tdata", m_tdata, e_data);
                chk("m_tuser", m_tuser, e_user);
                chk("m_tlast", m_tlast, e_last);
                chk("busy", busy, m_busy);
                chk("frame_done", frame_done, e_done);
                if (prev_stall) begin
                    chk("stall_tvalid", m_tvalid, 1'b1);
                    chk("stall_tdata", m_tdata, prev_data);
                    chk("stall_tuser", m_tuser, prev_user);
                    chk("stall_tlast", m_tlast, prev_last);
                end
            end
            prev_stall = !rst && m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_user  = m_tuser;
            prev_last  = m_tlast;
            if (!rst && m_tvalid && m_tready) beat_log.push_back({m_tuser, m_tlast, m_tdata});
            if (frame_done) fd_cnt++;
            if (rst) begin
                mq.delete();
                m_acc  = 0;
                m_pos  = 0;
                m_busy = 1'b0;
            end else begin
                if (start && !m_busy) begin
                    m_busy = 1'b1;
                    m_acc  = 0;
                end
                if (pix_valid && e_ready) begin
                    mq.push_back(pix_data);
                    m_acc++;
                end
                if (e_valid && m_tready) begin
                    void'(mq.pop_front());
                    if (m_pos == NPIX - 1) begin
                        m_pos  = 0;
                        m_busy = 1'b0;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
    end

    task automatic step(input int vpct, input int rpct, input int max_acc);
        pix_valid = (sent < max_acc) && ($urandom_range(99, 0) < vpct);
        pix_data  = next_pix[23:0];
        m_tready  = ($urandom_range(99, 0) < rpct);
        @(negedge clk);
        #1;
        if (pix_valid && pix_ready) begin
            sent++;
            next_pix++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int rpct);
        pix_valid = 1'b0;
        m_tready  = ($urandom_range(99, 0) < rpct);
        start     = 1'b1;
        sent      = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            step(100, 100, NPIX);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
        pix_valid = 1'b0;
    endtask

    task automatic check_frame_marks(input int base, input string name);
        logic [1:0] e;
        chk({name, "_beats"}, beat_log.size() - base, NPIX);
        for (int i = 0; i < NPIX; i++) begin
            e = {(i == 0), ((i % FW) == FW - 1)};
            if (base + i < beat_log.size()) chk({name, "_marks"}, beat_log[base + i][25:24], e);
        end
    endtask

    initial begin
        int base, fd0, fresh, n;
        logic [25:0] e;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_tdata", m_tdata, 24'h0);
        chk("rst_tuser_tlast", {m_tuser, m_tlast, frame_done}, 3'b000);

        // 1: full-rate frame, data 1..8
        base = beat_log.size(); fd0 = fd_cnt; next_pix = 1;
        start_frame(100);
        repeat (14) step(100, 100, NPIX);
        chk("t1_beats", beat_log.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            e = {(i == 0), (i == 3 || i == 7), 24'(i + 1)};
            if (base + i < beat_log.size()) chk("t1_beat", beat_log[base + i], e);
        end
        chk("t1_done_cnt", fd_cnt - fd0, 1);
        chk("t1_busy", busy, 1'b0);

        // 2: sink stalled, only the FIFO depth is accepted
        base = beat_log.size(); fd0 = fd_cnt;
        start_frame(0);
        repeat (10) step(100, 0, 6);
        chk("t2_accepted", sent, 4);
        chk("t2_pix_ready", pix_ready, 1'b0);
        chk("t2_tdata_head", m_tdata, 24'd9);
        n = 0;
        while (sent < NPIX && n < 40) begin step(100, 100, NPIX); n++; end
        wait_idle(20);
        chk("t2_beats", beat_log.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < beat_log.size()) chk("t2_data", beat_log[base + i][23:0], 24'(9 + i));
        chk("t2_done_cnt", fd_cnt - fd0, 1);

        // 3: three back-to-back frames with random valid/ready
        for (int f = 0; f < 3; f++) begin
            base = beat_log.size(); fd0 = fd_cnt;
            start_frame(50);
            n = 0;
            while (sent < NPIX && n < 400) begin step(60, 50, NPIX); n++; end
            chk("t3_fed", sent, NPIX);
            wait_idle(40);
            check_frame_marks(base, "t3");
            chk("t3_done_cnt", fd_cnt - fd0, 1);
        end

        // 4: start ignored in ACTIVE and FLUSH, pixels ignored in IDLE
        base = beat_log.size(); fd0 = fd_cnt;
        start_frame(100);
        repeat (3) step(100, 100, NPIX);
        start_frame(100);
        sent = 3;
        chk("t4_busy_active", busy, 1'b1);
        n = 0;
        while (sent < NPIX && n < 40) begin step(100, 100, NPIX); n++; end
        pix_valid = 1'b0; m_tready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_busy_flush", busy, 1'b1);
        wait_idle(20);
        chk("t4_beats", beat_log.size() - base, 8);
        chk("t4_done_cnt", fd_cnt - fd0, 1);
        base = beat_log.size(); fresh = next_pix;
        for (int i = 0; i < 5; i++) begin
            step(100, 100, 100);
            chk("t4_idle_ready", pix_ready, 1'b0);
            chk("t4_idle_tvalid", m_tvalid, 1'b0);
        end
        pix_valid = 1'b0;
        chk("t4_idle_beats", beat_log.size() - base, 0);
        chk("t4_idle_nopix", next_pix, fresh);

        // 5: reset after five beats, then a clean frame
        base = beat_log.size(); fd0 = fd_cnt;
        start_frame(100);
        n = 0;
        while (beat_log.size() < base + 5 && n < 40) begin step(100, 100, NPIX); n++; end
        chk("t5_five_beats", beat_log.size() - base, 5);
        pix_valid = 1'b0; m_tready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_tvalid", m_tvalid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        repeat (3) step(0, 100, NPIX);
        chk("t5_no_done", fd_cnt - fd0, 0);
        base = beat_log.size(); fresh = next_pix;
        start_frame(100);
        n = 0;
        while (sent < NPIX && n < 40) begin step(100, 100, NPIX); n++; end
        wait_idle(20);
        e = {1'b1, 1'b0, 24'(fresh)};
        if (base < beat_log.size()) chk("t5_first_beat", beat_log[base], e);
        check_frame_marks(base, "t5");

        // 6: full FIFO then occupancy-1 push/pop, several pointer laps
        for (int f = 0; f < 2; f++) begin
            base = beat_log.size(); fresh = next_pix;
            start_frame(0);
            repeat (6) step(100, 0, NPIX);
            chk("t6_full_accept", sent, DEP);
            n = 0;
            while (sent < NPIX && n < 40) begin step(100, 100, NPIX); n++; end
            wait_idle(20);
            chk("t6_beats", beat_log.size() - base, 8);
            for (int i = 0; i < 8; i++)
                if (base + i < beat_log.size())
                    chk("t6_order", beat_log[base + i][23:0], 24'(fresh + i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
